// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S transmitter.
// Optional feature macro: I2S_TX_UNDERRUN_CNT_EN (underrun counter width lives here).
package i2s_pkg;

    typedef enum logic {e_idle, e_run} i2s_state_e;

    localparam int I2S_UNDERRUN_CNT_W = 16;

    function automatic logic [I2S_UNDERRUN_CNT_W-1:0] sat_inc(
        input logic [I2S_UNDERRUN_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: valid/ready sample stream from the tone source into i2s_tx.
// Master drives valid/data, slave returns ready.
interface i2s_tx_if #(
    parameter int width_p = 24
) ();

    logic               valid;
    logic [width_p-1:0] data;
    logic               ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK/LRCLK generation and bit position within the I2S frame.
// Held cleared while en_i is low so a run always starts at bit 0 with BCLK low.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int slot_width_p = 32,
    parameter int sclk_div_p   = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              en_i,
    output logic                              bclk_o,
    output logic                              lrclk_o,
    output logic                              bclk_fall_o,
    output logic                              frame_start_o,
    output logic [$clog2(2*slot_width_p)-1:0] bit_cnt_nxt_o
);

    localparam int bit_w_lp = $clog2(2*slot_width_p);
    localparam int div_w_lp = $clog2(sclk_div_p);

    localparam logic [div_w_lp-1:0] div_max_lp  = div_w_lp'(sclk_div_p - 1);
    localparam logic [bit_w_lp-1:0] bit_max_lp  = bit_w_lp'(2*slot_width_p - 1);
    localparam logic [bit_w_lp-1:0] slot_lp     = bit_w_lp'(slot_width_p);

    logic [div_w_lp-1:0] div_cnt_q, div_cnt_d;
    logic [bit_w_lp-1:0] bit_cnt_q, bit_cnt_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                fall, frame_start;

    always_comb begin
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        fall        = 1'b0;
        frame_start = 1'b0;
        if (!en_i) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
        end else if (div_cnt_q == div_max_lp) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            // bit position and word select only move on BCLK falling edges
            if (bclk_q) begin
                fall = 1'b1;
                if (bit_cnt_q == bit_max_lp) begin
                    bit_cnt_d   = '0;
                    frame_start = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                lrclk_d = (bit_cnt_d >= slot_lp);
            end
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
        end
    end

    assign bclk_o        = bclk_q;
    assign lrclk_o       = lrclk_q;
    assign bclk_fall_o   = fall;
    assign frame_start_o = frame_start;
    assign bit_cnt_nxt_o = bit_cnt_d;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: mono Philips-I2S transmitter, one sample per frame sent in both slots.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt_o port.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int width_p      = 24,
    parameter int slot_width_p = 32,
    parameter int sclk_div_p   = 4
) (
    input  logic    clk_i,
    input  logic    reset_i,
    i2s_tx_if.slave in_if,
    output logic    bclk_o,
    output logic    lrclk_o,
    output logic    sdata_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [I2S_UNDERRUN_CNT_W-1:0] underrun_cnt_o
`endif
);

    localparam int bit_w_lp = $clog2(2*slot_width_p);
    localparam int pad_lp   = slot_width_p - 1 - width_p;

    localparam logic [bit_w_lp-1:0] slot_lp = bit_w_lp'(slot_width_p);

    i2s_state_e          state_q, state_d;
    logic [width_p-1:0]  hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                ready_q, ready_d;
    logic [width_p-1:0]  frame_q, frame_d;
    logic                sdata_q, sdata_d;
    logic                accept;
    logic                bclk_fall, frame_start;
    logic [bit_w_lp-1:0] bit_cnt_nxt;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [I2S_UNDERRUN_CNT_W-1:0] under_q, under_d;
`endif

    i2s_clkgen #(
        .slot_width_p (slot_width_p),
        .sclk_div_p   (sclk_div_p)
    ) u_clkgen (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .en_i          (state_q == e_run),
        .bclk_o        (bclk_o),
        .lrclk_o       (lrclk_o),
        .bclk_fall_o   (bclk_fall),
        .frame_start_o (frame_start),
        .bit_cnt_nxt_o (bit_cnt_nxt)
    );

    // Slot bit 0 is the one-BCLK I2S delay; sample MSB sits at slot bit 1.
    function automatic logic slot_bit(
        input logic [bit_w_lp-1:0] bc,
        input logic [width_p-1:0]  smp
    );
        logic [bit_w_lp-1:0]     k;
        logic [slot_width_p-1:0] word;
        k    = (bc >= slot_lp) ? bc - slot_lp : bc;
        word = slot_width_p'(smp) << pad_lp;
        word = word << k;
        return word[slot_width_p-1];
    endfunction

    assign accept = in_if.valid & ready_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        frame_d      = frame_q;
        sdata_d      = sdata_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        under_d      = under_q;
`endif
        if (accept) begin
            hold_d       = in_if.data;
            hold_valid_d = 1'b1;
        end
        unique case (state_q)
            e_idle: begin
                sdata_d = 1'b0;
                if (hold_valid_q) begin
                    state_d      = e_run;
                    frame_d      = hold_q;
                    hold_valid_d = 1'b0;
                end
            end
            e_run: begin
                if (bclk_fall) begin
                    // an empty hold at the boundary replays the last sample
                    if (frame_start) begin
                        if (hold_valid_q) begin
                            frame_d      = hold_q;
                            hold_valid_d = 1'b0;
                        end else begin
`ifdef I2S_TX_UNDERRUN_CNT_EN
                            under_d = sat_inc(under_q);
`endif
                        end
                    end
                    sdata_d = slot_bit(bit_cnt_nxt, frame_d);
                end
            end
        endcase
    end

    assign ready_d = ~hold_valid_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= e_idle;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            frame_q      <= '0;
            sdata_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ready_q      <= ready_d;
            frame_q      <= frame_d;
            sdata_q      <= sdata_d;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            under_q <= '0;
        end else begin
            under_q <= under_d;
        end
    end

    assign underrun_cnt_o = under_q;
`endif

    assign in_if.ready = ready_q;
    assign sdata_o     = sdata_q;

endmodule
